pc_fetch_unit: RTL and testbench

- Instruction-fetch front end of the RISC-V core.
- Holds the architectural PC and drives it into the PC+4 adder, then consumes the adder sum as the sequential next PC.
- Issues one-outstanding fetch requests to instruction memory over a req/gnt/rvalid handshake and presents fetched instructions to decode through a single-entry valid/ready buffer with a one-entry skid.
- Accepts redirects (branch/jump/trap) from execute, with squash of in-flight and buffered fetches.

---
 rtl/pc_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the architectural PC, issues one outstanding
// fetch at a time over req/gnt/rvalid and hands instructions to decode through a
// single-entry valid/ready buffer backed by a one-entry skid register.
module pc_fetch_unit #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] pc_o,
   input  logic [WIDTH-1:0] pc_plus4_i,
   input  logic             redirect_i,
   input  logic [WIDTH-1:0] redirect_pc_i,
   output logic             imem_req_o,
   output logic [WIDTH-1:0] imem_addr_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   input  logic [31:0]      imem_rdata_i,
   output logic             if_valid_o,
   output logic [31:0]      if_instr_o,
   output logic [WIDTH-1:0] if_pc_o,
   input  logic             id_ready_i
);

   typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic             discard_q, discard_d;
   logic             valid_q, valid_d;
   logic [31:0]      instr_q, instr_d;
   logic [WIDTH-1:0] ipc_q, ipc_d;
   logic [31:0]      skid_instr_q, skid_instr_d;
   logic [WIDTH-1:0] skid_pc_q, skid_pc_d;

   logic             transfer;
   logic [WIDTH-1:0] redirect_aligned;

   assign transfer         = valid_q & id_ready_i;
   assign redirect_aligned = {redirect_pc_i[WIDTH-1:2], 2'b00};

   // Request is a pure decode of state; rst_n gating keeps it low during reset.
   assign pc_o        = pc_q;
   assign imem_addr_o = pc_q;
   assign imem_req_o  = rst_n & (state_q == StFetch);
   assign if_valid_o  = valid_q;
   assign if_instr_o  = instr_q;
   assign if_pc_o     = ipc_q;

   // Next-state logic: redirect overrides everything; otherwise the fetch handshake.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_pc_d   = fetch_pc_q;
      discard_d    = discard_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      ipc_d        = ipc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;

      // A consumed entry leaves unless something reloads it below.
      if (transfer) begin
         valid_d = 1'b0;
      end

      if (redirect_i) begin
         pc_d         = redirect_aligned;
         valid_d      = 1'b0;
         skid_instr_d = '0;
         skid_pc_d    = '0;
         unique case (state_q)
            StFetch: begin
               // Granted request is already in flight: mark its response stale.
               if (imem_gnt_i) begin
                  state_d   = StWait;
                  discard_d = 1'b1;
               end
            end
            StWait: begin
               if (imem_rvalid_i) begin
                  state_d   = StFetch;
                  discard_d = 1'b0;
               end else begin
                  discard_d = 1'b1;
               end
            end
            StHold:  state_d = StFetch;
            default: state_d = StFetch;
         endcase
      end else begin
         unique case (state_q)
            StFetch: begin
               if (imem_gnt_i) begin
                  state_d    = StWait;
                  fetch_pc_d = pc_q;
                  pc_d       = pc_plus4_i;
               end
            end
            StWait: begin
               if (imem_rvalid_i) begin
                  if (discard_q) begin
                     discard_d = 1'b0;
                     state_d   = StFetch;
                  end else if (!valid_q || transfer) begin
                     instr_d = imem_rdata_i;
                     ipc_d   = fetch_pc_q;
                     valid_d = 1'b1;
                     state_d = StFetch;
                  end else begin
                     skid_instr_d = imem_rdata_i;
                     skid_pc_d    = fetch_pc_q;
                     state_d      = StHold;
                  end
               end
            end
            StHold: begin
               if (transfer) begin
                  instr_d      = skid_instr_q;
                  ipc_d        = skid_pc_q;
                  valid_d      = 1'b1;
                  skid_instr_d = '0;
                  skid_pc_d    = '0;
                  state_d      = StFetch;
               end
            end
            default: state_d = StFetch;
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StFetch;
         pc_q         <= RESET_PC;
         fetch_pc_q   <= '0;
         discard_q    <= 1'b0;
         valid_q      <= 1'b0;
         instr_q      <= '0;
         ipc_q        <= '0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetch_pc_q   <= fetch_pc_d;
         discard_q    <= discard_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         ipc_q        <= ipc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: behavioural instruction memory with a grant budget and
// configurable latency, a decode-side scoreboard and a log of granted addresses.
module tb_pc_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct {
      logic [31:0] target;
      int unsigned lat;
      int unsigned n;
      logic [31:0] exp_addr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready = 1'b1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   exp_t        exp_q[$];
   logic [31:0] exp_grant_q[$];
   logic [31:0] grant_q[$];
   exp_t        cur;

   int unsigned lat = 1;
   int unsigned grants_allow = 0;
   int unsigned grants_used = 0;
   int unsigned mcnt = 0;
   logic        mbusy = 1'b0;
   logic [31:0] pend_addr = '0;
   logic [31:0] maddr = '0;

   vec_t vecs[4];

   assign pc_plus4 = pc_o + 32'd4;

   pc_fetch_unit #(
      .WIDTH    (32),
      .RESET_PC (32'h0000_1000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_o          (pc_o),
      .pc_plus4_i    (pc_plus4),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_gnt_i    (imem_gnt),
      .imem_rvalid_i (imem_rvalid),
      .imem_rdata_i  (imem_rdata),
      .if_valid_o    (if_valid),
      .if_instr_o    (if_instr),
      .if_pc_o       (if_pc),
      .id_ready_i    (id_ready)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Memory: grants only within the budget, answers 'lat' cycles after grant.
   always @(negedge clk) begin
      imem_rvalid = 1'b0;
      if (!rst_n) begin
         mbusy    = 1'b0;
         imem_gnt = 1'b0;
      end else begin
         if (imem_gnt) begin
            mbusy = 1'b1;
            mcnt  = lat;
            maddr = pend_addr;
         end
         if (mbusy) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = instr_of(maddr);
               mbusy       = 1'b0;
            end
         end
         imem_gnt = imem_req && !mbusy && (grants_used < grants_allow);
         if (imem_gnt) begin
            pend_addr   = imem_addr;
            grants_used = grants_used + 1;
         end
      end
   end

   // Monitor just before each rising edge: log grants, score transfers to decode.
   always @(negedge clk) begin
      #4;
      if (rst_n) begin
         if (imem_req && imem_gnt) grant_q.push_back(imem_addr);
         if (if_valid && id_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_transfer: got pc %h, expected no transfer", if_pc);
            end else begin
               cur = exp_q.pop_front();
               check("xfer_pc", if_pc, cur.pc);
               check("xfer_instr", if_instr, cur.instr);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] base, input int unsigned n);
      for (int i = 0; i < int'(n); i++) begin
         logic [31:0] a;
         a = base + 32'(4 * i);
         exp_q.push_back('{pc: a, instr: instr_of(a)});
         exp_grant_q.push_back(a);
      end
   endtask

   task automatic drain(input string name);
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 200) begin
         tick();
         cyc++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d pending, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (3) tick();
   endtask

   task automatic check_grants(input string name);
      check({name, "_grant_count"}, 32'(grant_q.size()), 32'(exp_grant_q.size()));
      for (int i = 0; i < grant_q.size() && i < exp_grant_q.size(); i++) begin
         check({name, "_grant_addr"}, grant_q[i], exp_grant_q[i]);
      end
      grant_q.delete();
      exp_grant_q.delete();
   endtask

   task automatic redirect_to(input logic [31:0] target);
      redirect_i  = 1'b1;
      redirect_pc = target;
      tick();
      redirect_i  = 1'b0;
   endtask

   task automatic wait_grant(input string name);
      int cyc;
      cyc = 0;
      while (!(imem_req && imem_gnt) && cyc < 50) begin
         tick();
         cyc++;
      end
      if (cyc == 50) begin
         checks++;
         errors++;
         $display("FAIL %s_grant_wait: got no grant, expected one within 50 cycles", name);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      vecs[0] = '{target: 32'h0000_5001, lat: 1, n: 3, exp_addr: 32'h0000_5000};
      vecs[1] = '{target: 32'h0000_6003, lat: 2, n: 2, exp_addr: 32'h0000_6000};
      vecs[2] = '{target: 32'h7FFF_FFFE, lat: 3, n: 2, exp_addr: 32'h7FFF_FFFC};
      vecs[3] = '{target: 32'hFFFF_FFFF, lat: 1, n: 2, exp_addr: 32'hFFFF_FFFC};

      // Reset values.
      repeat (2) tick();
      check("reset_req", 32'(imem_req), 32'd0);
      check("reset_pc", pc_o, 32'h0000_1000);
      check("reset_valid", 32'(if_valid), 32'd0);
      check("reset_instr", if_instr, 32'd0);
      check("reset_if_pc", if_pc, 32'd0);
      rst_n = 1'b1;
      tick();
      check("post_reset_req", 32'(imem_req), 32'd1);
      check("post_reset_addr", imem_addr, 32'h0000_1000);

      // Streaming, 1-cycle memory, decode always ready.
      push_exp(32'h0000_1000, 4);
      grants_allow = grants_allow + 4;
      drain("stream");
      check_grants("stream");
      check("stream_pc", pc_o, 32'h0000_1010);
      check("stream_idle_valid", 32'(if_valid), 32'd0);

      // Backpressure after the first instruction fills buffer and skid.
      redirect_to(32'h0000_1000);
      push_exp(32'h0000_1000, 3);
      grants_allow = grants_allow + 3;
      cyc = 0;
      while (exp_q.size() == 3 && cyc < 50) begin
         tick();
         cyc++;
      end
      id_ready = 1'b0;
      repeat (8) tick();
      check("bp_hold_req", 32'(imem_req), 32'd0);
      check("bp_hold_valid", 32'(if_valid), 32'd1);
      check("bp_hold_pc", if_pc, 32'h0000_1004);
      check("bp_pending", 32'(exp_q.size()), 32'd2);
      id_ready = 1'b1;
      drain("bp");
      check_grants("bp");

      // Redirect in the same cycle as the grant for 1008.
      redirect_to(32'h0000_1000);
      push_exp(32'h0000_1000, 2);
      exp_grant_q.push_back(32'h0000_1008);
      grants_allow = grants_allow + 3;
      cyc = 0;
      while (!(imem_req && imem_gnt && imem_addr == 32'h0000_1008) && cyc < 50) begin
         tick();
         cyc++;
      end
      redirect_to(32'h0000_2002);
      check("rg_pc", pc_o, 32'h0000_2000);
      push_exp(32'h0000_2000, 2);
      grants_allow = grants_allow + 2;
      drain("rg");
      check_grants("rg");

      // Redirect while waiting on a 3-cycle memory.
      lat = 3;
      exp_grant_q.push_back(32'h0000_2008);
      grants_allow = grants_allow + 1;
      wait_grant("rw");
      redirect_to(32'h0000_3000);
      repeat (4) tick();
      check("rw_valid", 32'(if_valid), 32'd0);
      check("rw_req", 32'(imem_req), 32'd1);
      check("rw_addr", imem_addr, 32'h0000_3000);
      push_exp(32'h0000_3000, 2);
      grants_allow = grants_allow + 2;
      drain("rw");
      check_grants("rw");

      // Redirect with buffer and skid both full.
      lat = 1;
      id_ready = 1'b0;
      exp_grant_q.push_back(32'h0000_3008);
      exp_grant_q.push_back(32'h0000_300C);
      grants_allow = grants_allow + 2;
      repeat (12) tick();
      check("flush_hold_req", 32'(imem_req), 32'd0);
      check("flush_hold_valid", 32'(if_valid), 32'd1);
      check("flush_hold_pc", if_pc, 32'h0000_3008);
      redirect_to(32'h0000_4000);
      check("flush_valid", 32'(if_valid), 32'd0);
      check("flush_addr", imem_addr, 32'h0000_4000);
      id_ready = 1'b1;
      push_exp(32'h0000_4000, 2);
      grants_allow = grants_allow + 2;
      drain("flush");
      check_grants("flush");

      // Table of redirect targets, latencies and lengths (last entry wraps).
      for (int v = 0; v < 4; v++) begin
         lat = vecs[v].lat;
         redirect_to(vecs[v].target);
         check("tbl_addr", imem_addr, vecs[v].exp_addr);
         push_exp(vecs[v].exp_addr, vecs[v].n);
         grants_allow = grants_allow + vecs[v].n;
         drain("tbl");
         check_grants("tbl");
      end
      check("wrap_pc", pc_o, 32'h0000_0004);

      // Asynchronous reset while waiting, with a full buffer.
      lat = 3;
      id_ready = 1'b0;
      exp_grant_q.push_back(32'h0000_0004);
      exp_grant_q.push_back(32'h0000_0008);
      grants_allow = grants_allow + 2;
      cyc = 0;
      while (grant_q.size() < 2 && cyc < 50) begin
         tick();
         cyc++;
      end
      check("mr_valid_before", 32'(if_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mr_req", 32'(imem_req), 32'd0);
      check("mr_pc", pc_o, 32'h0000_1000);
      check("mr_valid", 32'(if_valid), 32'd0);
      check("mr_instr", if_instr, 32'd0);
      check("mr_if_pc", if_pc, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      check_grants("mr");
      id_ready = 1'b1;
      push_exp(32'h0000_1000, 1);
      grants_allow = grants_allow + 1;
      drain("mr_restart");
      check_grants("mr_restart");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
